// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction/start inputs and datapath control outputs of the control_fsm sequencer
interface control_fsm_if;
    logic        run;
    logic [15:0] din;
    logic        g_nz;
    logic [2:0]  rout;
    logic        din_en;
    logic        gout;
    logic [7:0]  rin;
    logic        ain;
    logic        gin;
    logic        addsub;
    logic        done;
    logic        busy;
    modport master (
        output run, din, g_nz,
        input  rout, din_en, gout, rin, ain, gin, addsub, done, busy
    );
    modport slave (
        input  run, din, g_nz,
        output rout, din_en, gout, rin, ain, gin, addsub, done, busy
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: T0-T3 instruction sequencer; optional mvnz opcode enabled by CTRL_MVNZ_EN
module control_fsm (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    state_t     state, state_nxt;
    logic [8:0] ir;
    logic [2:0] op, x, y;
    logic [7:0] x_hot;
    logic       unused_din;
    assign op         = ir[8:6];
    assign x          = ir[5:3];
    assign y          = ir[2:0];
    assign x_hot      = 8'd1 << x;
    assign bus.busy   = state != IDLE;
    assign unused_din = ^bus.din[15:9];
`ifndef CTRL_MVNZ_EN
    logic unused_g_nz;
    assign unused_g_nz = bus.g_nz;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.run) ir <= bus.din[8:0];
        end
    end
    always_comb begin
        state_nxt  = state;
        bus.rout   = 3'd0;
        bus.din_en = 1'b0;
        bus.gout   = 1'b0;
        bus.rin    = 8'd0;
        bus.ain    = 1'b0;
        bus.gin    = 1'b0;
        bus.addsub = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: state_nxt = bus.run ? T1 : IDLE;
            T1: begin
                state_nxt = (op == 3'b010 || op == 3'b011) ? T2 : IDLE;
                bus.done  = state_nxt == IDLE;
                case (op)
                    3'b000: begin
                        bus.rout = y;
                        bus.rin  = x_hot;
                    end
                    3'b001: begin
                        bus.din_en = 1'b1;
                        bus.rin    = x_hot;
                    end
                    3'b010, 3'b011: begin
                        bus.rout = x;
                        bus.ain  = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    3'b100: begin
                        bus.rout = bus.g_nz ? y : 3'd0;
                        bus.rin  = bus.g_nz ? x_hot : 8'd0;
                    end
`endif
                    default: ;
                endcase
            end
            // only add/sub reach T2/T3, so no opcode check is needed here
            T2: begin
                state_nxt  = T3;
                bus.rout   = y;
                bus.gin    = 1'b1;
                bus.addsub = ir[6];
            end
            T3: begin
                state_nxt = IDLE;
                bus.gout  = 1'b1;
                bus.rin   = x_hot;
                bus.done  = 1'b1;
            end
        endcase
    end
endmodule
